// File: rtl/spi_regfile_responder_if.sv
// spi_regfile_responder_if
//   Pin bundle between an SPI master and the register-file responder.
//   Ports (as seen by the master modport):
//     sclk    out  SPI clock
//     cs_n    out  chip select, active low
//     mosi    out  master-out data, MSB first
//     miso    in   responder-out data
//     miso_oe in   responder output enable (frame active)
interface spi_regfile_responder_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, cs_n, mosi, input miso, miso_oe);
  modport slave  (input sclk, cs_n, mosi, output miso, miso_oe);
endinterface

// File: rtl/spi_regfile_responder.sv
// spi_regfile_responder
//   SPI target that owns a 16x8 register file. A frame starts with a command
//   byte (bit7 = read, bits[3:0] = address) followed by any number of data
//   bytes; the address auto-increments (mod 16) after every data byte.
//   All SPI pins are oversampled on clk; sclk is never used as a clock.
//   Ports:
//     clk        system clock
//     reset      asynchronous, active-low reset
//     mode       {CPOL,CPHA}, latched when a frame starts
//     spi        SPI pins (slave modport): sclk/cs_n/mosi in, miso/miso_oe out
//     wr_valid   one-clk pulse per committed write, with wr_addr/wr_data
//     dbg_addr   debug read address; dbg_data = regfile[dbg_addr] (comb)
//     busy       state != IDLE
//     frame_err  one-clk pulse when a frame ends mid-byte
module spi_regfile_responder #(
  parameter int NREGS       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  spi_regfile_responder_if.slave spi,
  output logic                   wr_valid,
  output logic [3:0]             wr_addr,
  output logic [7:0]             wr_data,
  input  logic [3:0]             dbg_addr,
  output logic [7:0]             dbg_data,
  output logic                   busy,
  output logic                   frame_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CMD      = 2'd1;
  localparam logic [1:0] DATA     = 2'd2;
  localparam logic [1:0] WAIT_CSH = 2'd3;

  localparam int            SW          = $clog2(SYNC_STAGES + 2);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic lead_edge, trail_edge, sample_edge, shift_edge;

  logic [1:0]    state;
  logic [SW-1:0] settle;
  logic [1:0]    mode_q;
  logic [2:0]    bit_cnt;
  logic [6:0]    rx;
  logic [7:0]    byte_in;
  logic [7:0]    tx;
  logic          rw;
  logic [3:0]    addr;
  logic [3:0]    addr_inc;
  logic          miso_q;
  logic          oe_q;
  logic [7:0]    regs [NREGS];

  // Input synchronizers plus one extra flop on sclk/cs_n for edge detection.
  // cs_n resets to its inactive level so reset itself never looks like a
  // frame start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  // Leading edge leaves the CPOL idle level; CPHA picks which edge samples.
  assign lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
  assign trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
  assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
  assign shift_edge  = mode_q[0] ? lead_edge : trail_edge;

  assign byte_in  = {rx, mosi_s};
  assign addr_inc = addr + 4'd1;

  // Frame FSM, register file and output registers. The settle counter keeps
  // the FSM in IDLE until the synchronizers hold real pin values after reset;
  // if cs_n is low at that point the frame in flight is ignored (WAIT_CSH).
  // A cs_n rise takes priority over any sclk edge seen in the same clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      settle    <= SETTLE_INIT;
      mode_q    <= 2'b00;
      bit_cnt   <= 3'd0;
      rx        <= 7'd0;
      tx        <= 8'd0;
      rw        <= 1'b0;
      addr      <= 4'd0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= 4'd0;
      wr_data   <= 8'd0;
      frame_err <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'd0;
    end else begin
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (settle != '0) settle <= settle - 1'b1;

      if (state != IDLE && cs_rise) begin
        state   <= IDLE;
        oe_q    <= 1'b0;
        miso_q  <= 1'b0;
        tx      <= 8'd0;
        bit_cnt <= 3'd0;
        if (bit_cnt != 3'd0) frame_err <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (settle == SW'(1)) begin
              if (!cs_s) state <= WAIT_CSH;
            end else if (settle == '0 && cs_fall) begin
              state   <= CMD;
              mode_q  <= mode;
              bit_cnt <= 3'd0;
              rx      <= 7'd0;
              tx      <= 8'd0;
              miso_q  <= 1'b0;
              oe_q    <= 1'b1;
            end
          end
          CMD, DATA: begin
            if (sample_edge) begin
              rx      <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state == CMD) begin
                  rw    <= byte_in[7];
                  addr  <= byte_in[3:0];
                  tx    <= byte_in[7] ? regs[byte_in[3:0]] : 8'd0;
                  state <= DATA;
                end else begin
                  if (rw) begin
                    tx <= regs[addr_inc];
                  end else begin
                    regs[addr] <= byte_in;
                    wr_valid   <= 1'b1;
                    wr_addr    <= addr;
                    wr_data    <= byte_in;
                  end
                  addr <= addr_inc;
                end
              end
            end else if (shift_edge) begin
              miso_q <= tx[7];
              tx     <= {tx[6:0], 1'b0};
            end
          end
          WAIT_CSH: begin
            state <= WAIT_CSH;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy        = (state != IDLE);
  assign dbg_data    = regs[dbg_addr];
  assign spi.miso    = miso_q;
  assign spi.miso_oe = oe_q;

endmodule
